// File: rtl/opb_simulink2ppc_fifo.sv
// ----------------------------------------------------------------------------
// opb_simulink2ppc_fifo
//
// OPB slave carrying 32-bit words from fabric logic to the PowerPC. Fabric
// pushes words into an on-chip FIFO; software pops them through the DATA
// register and monitors OVERFLOW/UNDERFLOW/count through STATUS.
//
// Register map (offset from C_BASEADDR, selected by OPB_ABus[28:29]):
//   0x0 DATA   read pops the head word (0 and UNDERFLOW when empty)
//   0x4 STATUS bit31 OVERFLOW, bit30 UNDERFLOW, bit[C_DEPTH_LOG2:0] count
//   0x8 CTRL   write: bit0 flush, bit1 clear sticky flags; reads 0
//   0xC        reserved, reads 0, writes ignored
//
// Ports:
//   OPB_Clk, OPB_Rst_n           single clock, async active-low reset
//   OPB_ABus/BE/DBus/RNW/select  OPB master side (big-endian bit numbering)
//   OPB_seqAddr                  unused
//   Sl_DBus, Sl_xferAck          read data (valid only in ack cycle), ack
//   Sl_errAck/retry/toutSup      tied to 0
//   user_data_in, user_valid     fabric push interface, one word per cycle
//   user_full                    registered FIFO-full indication
//
// Build option: define OPB_SNAP_RING_EN for ring mode, where a push into a
// full FIFO overwrites the oldest word instead of being dropped.
// ----------------------------------------------------------------------------
module opb_simulink2ppc_fifo #(
    parameter logic [31:0] C_BASEADDR   = 32'h01180C00,
    parameter logic [31:0] C_HIGHADDR   = 32'h01180CFF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter              C_FAMILY     = "virtex6",
    parameter int          C_DEPTH_LOG2 = 4
) (
    input  logic                      OPB_Clk,
    input  logic                      OPB_Rst_n,
    input  logic [0:C_OPB_AWIDTH-1]   OPB_ABus,
    input  logic [0:C_OPB_DWIDTH/8-1] OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1]   OPB_DBus,
    input  logic                      OPB_RNW,
    input  logic                      OPB_select,
    input  logic                      OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1]   Sl_DBus,
    output logic                      Sl_xferAck,
    output logic                      Sl_errAck,
    output logic                      Sl_retry,
    output logic                      Sl_toutSup,
    input  logic [C_OPB_DWIDTH-1:0]   user_data_in,
    input  logic                      user_valid,
    output logic                      user_full
);

    localparam int unsigned DEPTH = 1 << C_DEPTH_LOG2;
    localparam logic [C_DEPTH_LOG2:0]   FULL_COUNT = DEPTH[C_DEPTH_LOG2:0];
    localparam logic [C_DEPTH_LOG2-1:0] PTR_ONE    = C_DEPTH_LOG2'(1);
    localparam logic [C_DEPTH_LOG2:0]   CNT_ONE    = (C_DEPTH_LOG2 + 1)'(1);

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;

    // Storage and state
    logic [C_OPB_DWIDTH-1:0] mem [DEPTH];
    logic [C_DEPTH_LOG2-1:0] wr_ptr;
    logic [C_DEPTH_LOG2-1:0] rd_ptr;
    logic [C_DEPTH_LOG2:0]   count;
    logic                    overflow;
    logic                    underflow;
    logic                    busy;
    logic                    xfer_ack;
    logic                    full_q;
    logic [C_OPB_DWIDTH-1:0] rd_data_q;

    // Decode / control
    logic                    hit;
    logic                    start;
    logic [1:0]              reg_sel;
    logic                    is_empty;
    logic                    is_full;
    logic                    pop_req;
    logic                    pop;
    logic                    underflow_evt;
    logic                    ctrl_wr;
    logic                    flush;
    logic                    clr_flags;
    logic                    push_req;
    logic                    push_ok;
    logic                    overflow_evt;
    logic                    ring_wr;
    logic                    mem_we;
    logic [C_OPB_DWIDTH-1:0] status_word;
    logic [C_OPB_DWIDTH-1:0] rd_word;

    logic unused_ok;
    assign unused_ok = &{1'b0, OPB_seqAddr, OPB_DBus[0:C_OPB_DWIDTH-3]};

    always_comb begin
        hit      = OPB_select && (OPB_ABus >= C_BASEADDR) && (OPB_ABus <= C_HIGHADDR);
        // busy holds off a repeat ack while the master keeps select asserted
        start    = hit && !busy;
        reg_sel  = OPB_ABus[C_OPB_AWIDTH-4 +: 2];
        is_empty = (count == '0);
        is_full  = (count == FULL_COUNT);

        pop_req       = start && OPB_RNW && (reg_sel == REG_DATA);
        pop           = pop_req && !is_empty;
        underflow_evt = pop_req && is_empty;

        ctrl_wr   = start && !OPB_RNW && (reg_sel == REG_CTRL) && (|OPB_BE);
        flush     = ctrl_wr && OPB_DBus[C_OPB_DWIDTH-1];
        clr_flags = ctrl_wr && OPB_DBus[C_OPB_DWIDTH-2];

        // Flush beats a concurrent push; a concurrent pop frees a slot when full
        push_req     = user_valid && !flush;
        push_ok      = push_req && (!is_full || pop);
        overflow_evt = push_req && is_full && !pop;
`ifdef OPB_SNAP_RING_EN
        ring_wr      = overflow_evt;
`else
        ring_wr      = 1'b0;
`endif
        mem_we       = push_ok || ring_wr;

        status_word                   = '0;
        status_word[C_OPB_DWIDTH-1]   = overflow;
        status_word[C_OPB_DWIDTH-2]   = underflow;
        status_word[C_DEPTH_LOG2:0]   = count;

        case (reg_sel)
            REG_DATA:   rd_word = is_empty ? '0 : mem[rd_ptr];
            REG_STATUS: rd_word = status_word;
            default:    rd_word = '0;
        endcase
    end

    // Storage needs no reset; occupancy is tracked by count/pointers.
    // When full, wr_ptr == rd_ptr: a push+pop in one cycle reads the old head
    // and overwrites that same slot, which is the intended ordering.
    always_ff @(posedge OPB_Clk) begin
        if (mem_we) begin
            mem[wr_ptr] <= user_data_in;
        end
    end

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            busy      <= 1'b0;
            xfer_ack  <= 1'b0;
            full_q    <= 1'b0;
            rd_data_q <= '0;
        end else begin
            xfer_ack  <= start;
            rd_data_q <= (start && OPB_RNW) ? rd_word : '0;

            if (!OPB_select) begin
                busy <= 1'b0;
            end else if (start) begin
                busy <= 1'b1;
            end

            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (mem_we) begin
                    wr_ptr <= wr_ptr + PTR_ONE;
                end
                // Ring overwrite drops the oldest word by advancing the head
                if (pop || ring_wr) begin
                    rd_ptr <= rd_ptr + PTR_ONE;
                end
                if (push_ok && !pop) begin
                    count <= count + CNT_ONE;
                end else if (pop && !push_ok) begin
                    count <= count - CNT_ONE;
                end
            end

            // A new event in the same cycle as a clear keeps the flag set
            overflow  <= overflow_evt  || (overflow  && !clr_flags);
            underflow <= underflow_evt || (underflow && !clr_flags);

            full_q <= is_full;
        end
    end

    assign Sl_DBus    = rd_data_q;
    assign Sl_xferAck = xfer_ack;
    assign Sl_errAck  = 1'b0;
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;
    assign user_full  = full_q;

endmodule

// File: doc/opb_simulink2ppc_fifo.md
# opb_simulink2ppc_fifo

OPB slave that carries data in the direction opposite to the existing PPC-to-Simulink registers: fabric logic pushes 32-bit words into an on-chip FIFO, and the PowerPC pops them over OPB. The block sits on the ROACH2 OPB bus beside the other register slaves and runs on one clock. It gives software a loss-aware readback path for calibration and diagnostic words, with status flags and a flush control.

## Interface
- C_BASEADDR, 32'h01180C00, base of the 256-byte decode window
- C_HIGHADDR, 32'h01180CFF, top of the decode window
- C_OPB_AWIDTH, 32, OPB address width
- C_OPB_DWIDTH, 32, OPB data width
- C_FAMILY, "virtex6", target family string, informational only
- C_DEPTH_LOG2, 4, FIFO depth is 2^C_DEPTH_LOG2 words (16)
- OPB_Clk  in  1  single clock for the OPB side and the user side
- OPB_Rst_n  in  1  reset, asynchronous and active-low
- OPB_ABus  in  [0:31]  address
- OPB_BE  in  [0:3]  byte enables
- OPB_DBus  in  [0:31]  write data
- OPB_RNW  in  1  1 = read
- OPB_select  in  1  transaction qualifier
- OPB_seqAddr  in  1  ignored
- Sl_DBus  out  [0:31]  read data; Sl_DBus[31] is the register LSB
- Sl_xferAck  out  1  transfer acknowledge
- Sl_errAck, Sl_retry, Sl_toutSup  out  1 each  tied to 0
- user_data_in  in  [31:0]  word to push
- user_valid  in  1  push strobe, one word per cycle
- user_full  out  1  FIFO full, registered

## Operation
- Decode: a transaction is a hit when OPB_select=1 and C_BASEADDR ≤ OPB_ABus ≤ C_HIGHADDR. The register is selected by OPB_ABus[28:29].
- Offset 0x0, DATA, read: pops the head word. If the FIFO is empty, the read returns 0x00000000, sets the UNDERFLOW flag and changes nothing else. Writes are acked and ignored.
- Offset 0x4, STATUS, read-only: bit31 OVERFLOW (sticky), bit30 UNDERFLOW (sticky), bit[C_DEPTH_LOG2:0] count (0..16). All other bits are 0.
- Offset 0x8, CTRL, write with any BE set:
  - bit0=1 flushes the FIFO (count←0, pointers←0).
  - bit1=1 clears both sticky flags.
  - Reads return 0.
- Offset 0xC: reads return 0; writes are ignored; always acked.
- Push: user_valid=1 with count<depth writes the word at the tail.
- Push with count=depth: the word is dropped and OVERFLOW is set (default build; see Configuration).
- Simultaneous push and pop when full: both succeed and count stays at depth. No overflow is flagged.
- Simultaneous push and pop when empty: the pop returns 0 and sets UNDERFLOW. The push succeeds, giving count=1.
- Flush in the same cycle as a push: flush wins, the push is dropped, and no overflow is flagged.
- Clear-flags in the same cycle as a new overflow or underflow event: the new event wins and the flag stays set.
- Pointers are C_DEPTH_LOG2 bits wide and wrap modulo depth. Count is C_DEPTH_LOG2+1 bits wide.

## Timing
- Reset (asynchronous): FIFO empty, pointers 0, flags 0, Sl_DBus=0, Sl_xferAck=0, user_full=0.
- Ack cycle: a hit first seen in cycle N produces Sl_xferAck=1 in cycle N+1, for exactly one cycle.
- Read data: Sl_DBus carries valid read data only during the ack cycle and is 0 otherwise.
- One ack per transaction: an internal busy flag blocks a second ack until OPB_select has been low for at least one cycle. A select held high for several cycles produces exactly one ack and one pop.
- Side-effect timing: pops, flushes and flag clears take effect on the ack cycle edge. STATUS read in cycle N+1 reflects state at the end of cycle N.
- user_full: registered, and asserts the cycle after count reaches depth. Pushes while full follow the boundary rules in Operation.
- Reset asserted mid-transaction: Sl_xferAck drops immediately and no pop is committed.

## Configuration
- OPB_SNAP_RING_EN
  - Defined: ring mode. A push when full (without a pop) overwrites the oldest word, advances the head, and sets OVERFLOW. Count stays at depth and user_full stays 1 but is advisory.
  - Undefined: drop-new mode as described under Operation.

## Test plan
- Reset, then read STATUS at 0x01180C04 → 0x00000000, exactly one Sl_xferAck pulse.
- Push 0x11111111, 0x22222222, 0x33333333, then read DATA three times → values in order, then STATUS count=0. A fourth read → 0x00000000 and STATUS=0x40000000.
- Push 17 words 0..16 (default build) → STATUS=0x80000010, user_full=1, reads return 0..15. With OPB_SNAP_RING_EN: reads return 1..16.
- Fill to 16, then push and pop in the same cycle → pop returns word 0, count stays 16, OVERFLOW=0.
- Write CTRL=0x3 in the same cycle as user_valid=1 → count=0, flags=0, pushed word absent.
- Hold OPB_select high for 5 cycles on DATA with 2 words queued → one ack, one pop, count=1.
